hw_nios_nios2_gen2_0_cpu_ocimem_arbiter: RTL and testbench
==========================================================

// Module: hw_nios_nios2_gen2_0_cpu_ocimem_arbiter
// PURPOSE
//  Shares the single-port on-chip debug RAM (OCI memory) between the JTAG debug slave and the
//  CPU's Avalon debug-memory slave port. It decodes the JTAG slave's sysclk-domain
//  take_action_ocimem_* pulses and jdo fields into address-load, write and read operations,
//  with address auto-increment. It arbitrates those operations round-robin against CPU
//  accesses. JTAG read data is returned on MonDReg.
// PARAMETERS
//  ADDR_W      8     debug RAM word-address width (2**ADDR_W x 32-bit words)
//  RESET_ADDR  0     JTAG address register value after reset
// PORTS
//  clk                      in   1       system clock; single clock domain
//  reset_n                  in   1       asynchronous active-low reset
//  jdo                      in   38      JTAG data: address = jdo[17 +: ADDR_W], write data = jdo[34:3]
//  take_action_ocimem_a     in   1       1-cycle pulse: load JTAG address from jdo
//  take_action_ocimem_b     in   1       1-cycle pulse: JTAG write of jdo[34:3] at address, then address+1
//  take_no_action_ocimem_a  in   1       1-cycle pulse: JTAG read at address, then address+1
//  cpu_address              in   ADDR_W  Avalon word address
//  cpu_read / cpu_write     in   1       Avalon read / write request
//  cpu_writedata            in   32      Avalon write data
//  cpu_byteenable           in   4       Avalon byte enables
//  cpu_debugaccess          in   1       write permitted only when 1
//  cpu_readdata             out  32      Avalon read data; valid when cpu_read=1 and cpu_waitrequest=0
//  cpu_waitrequest          out  1       Avalon stall
//  ram_addr                 out  ADDR_W  debug RAM address
//  ram_wren                 out  1       debug RAM write enable
//  ram_byteen               out  4       debug RAM byte enables
//  ram_wdata                out  32      debug RAM write data
//  ram_rdata                in   32      debug RAM read data; 1-cycle registered latency
//  MonDReg                  out  32      last JTAG read data, or last JTAG write data
//  jtag_busy                out  1       JTAG op pending or in flight
//  jtag_overrun             out  1       sticky: a JTAG pulse arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset values:
//  - jaddr = RESET_ADDR; MonDReg, cpu_readdata = 0; FSM = IDLE; last_grant = CPU.
//  - jtag_busy, jtag_overrun, ram_wren = 0.
//  Address load:
//  - take_action_ocimem_a loads jaddr immediately. It does not use the RAM and never overruns.
//  Pending JTAG op:
//  - A read or write pulse latches a 1-deep pending op; the write also latches data.
//  - A read/write pulse while jtag_busy=1 is dropped and sets jtag_overrun.
//  - If more than one pulse arrives in the same cycle: a-load applies first, then the
//    read/write op uses the new address.
//  Arbitration in IDLE, one grant per cycle:
//  - Requesters: pending JTAG op; CPU (cpu_read|cpu_write).
//  - Both requesting: grant goes to the side not in last_grant. Single requester: granted.
//  - last_grant updates on every grant.
//  FSM IDLE:
//  - JTAG write grant: ram_wren=1, byteen=4'hF, addr=jaddr. MonDReg <= write data.
//    jaddr <= jaddr+1. Clear pending. Stay in IDLE.
//  - JTAG read grant: ram_addr=jaddr, go to JRD.
//  - CPU write grant: ram_wren=cpu_debugaccess, byteen=cpu_byteenable. The access completes in
//    that cycle (waitrequest=0) even when the write is suppressed.
//  - CPU read grant: ram_addr=cpu_address, go to CRD.
//  FSM JRD (1 cycle):
//  - MonDReg <= ram_rdata. jaddr <= jaddr+1. Clear pending. Return to IDLE.
//  FSM CRD (1 cycle):
//  - cpu_readdata <= ram_rdata, presented with waitrequest=0 this cycle. Return to IDLE.
//  - The CPU read latency is therefore 2 cycles with no contention.
//  Waitrequest and stalls:
//  - cpu_waitrequest = (cpu_read|cpu_write) & ~cpu_done, combinational.
//  - The CPU must hold its request stable while stalled.
//  Address and busy:
//  - jaddr wraps modulo 2**ADDR_W (all-ones+1 -> 0).
//  - jtag_busy = pending | (FSM == JRD).
//  Async reset mid-op: the in-flight op is abandoned, the pending op is discarded, and all
//  state returns to the reset values.
// TESTING
//  - Load and write: take_action_ocimem_a with jdo[17+:8]=8'h10, then take_action_ocimem_b with
//    jdo[34:3]=32'hDEADBEEF -> RAM[0x10]=DEADBEEF, MonDReg=DEADBEEF, jaddr=0x11.
//  - JTAG read: RAM[0x11]=0x12345678, take_no_action_ocimem_a -> MonDReg=0x12345678 two cycles
//    after the pulse, jaddr=0x12.
//  - Contention: continuous CPU reads of 0x20 plus a JTAG write pulse -> both requesters are
//    served in alternating grants, no CPU readdata corruption, JTAG write lands at jaddr.
//  - CPU write with cpu_debugaccess=0, data 0xA5A5A5A5 to 0x05 -> waitrequest low in the grant
//    cycle, RAM[0x05] unchanged. With debugaccess=1 and byteenable=4'b0011 -> only bytes 1:0
//    are updated.
//  - Overrun and wrap: two read pulses 1 cycle apart while the CPU holds the grant ->
//    jtag_overrun=1, one read performed. jaddr=0xFF followed by a write -> jaddr=0x00.
//  - Reset mid-read: assert reset_n=0 in JRD -> MonDReg=0, jtag_busy=0, FSM IDLE, jaddr=RESET_ADDR.

Source files
------------

// File: rtl/hw_nios_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Purpose: share the single-port OCI debug RAM between JTAG ops (decoded from jdo pulses) and the CPU Avalon port.
// Latency: JTAG write 1 cycle after pulse, JTAG read 2 cycles to MonDReg; CPU write 1 cycle, CPU read 2 cycles.
// Backpressure: CPU stalled via cpu_waitrequest; JTAG has a 1-deep pending slot, extra pulses set jtag_overrun.
module hw_nios_nios2_gen2_0_cpu_ocimem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  input  logic              cpu_debugaccess,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  localparam logic [ADDR_W-1:0] LP_RESET_ADDR = ADDR_W'(RESET_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_JRD  = 2'd1,
    ST_CRD  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_jaddr;
  logic              r_pend;
  logic              r_pend_wr;
  logic [31:0]       r_pend_data;
  logic              r_last_jtag;
  logic [31:0]       r_mondreg;
  logic [31:0]       r_cpu_rdata;
  logic              r_overrun;

  logic              w_grant_j;
  logic              w_grant_c;
  logic              w_cpu_done;
  logic              w_creq;
  logic              w_rw_pulse;
  logic              w_busy;
  logic              w_jwr_done;
  logic              w_jop_done;
  logic              w_unused;

  // jdo bits outside the address and data fields carry nothing for this block
  assign w_unused   = ^{jdo[37:35], jdo[2:0]};

  assign w_creq     = cpu_read | cpu_write;
  assign w_rw_pulse = take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_busy     = r_pend | (r_state == ST_JRD);
  // a JTAG op retires either on its write grant or in the read-return cycle
  assign w_jwr_done = w_grant_j & r_pend_wr;
  assign w_jop_done = w_jwr_done | (r_state == ST_JRD);

  assign jtag_busy       = w_busy;
  assign jtag_overrun    = r_overrun;
  assign MonDReg         = r_mondreg;
  assign cpu_waitrequest = w_creq & ~w_cpu_done;
  // read data is forwarded straight from the RAM in the completion cycle, then held
  assign cpu_readdata    = (r_state == ST_CRD) ? ram_rdata : r_cpu_rdata;

  // round-robin grant, RAM drive and next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant_j   = 1'b0;
    w_grant_c   = 1'b0;
    w_cpu_done  = 1'b0;
    ram_addr    = r_jaddr;
    ram_wren    = 1'b0;
    ram_byteen  = 4'hF;
    ram_wdata   = r_pend_data;
    case (r_state)
      ST_IDLE: begin
        if (r_pend && (!w_creq || !r_last_jtag)) begin
          w_grant_j = 1'b1;
        end else if (w_creq) begin
          w_grant_c = 1'b1;
        end
        if (w_grant_j) begin
          if (r_pend_wr) begin
            ram_wren = 1'b1;
          end else begin
            w_state_nxt = ST_JRD;
          end
        end else if (w_grant_c) begin
          ram_addr = cpu_address;
          if (cpu_write) begin
            ram_wren   = cpu_debugaccess;
            ram_byteen = cpu_byteenable;
            ram_wdata  = cpu_writedata;
            w_cpu_done = 1'b1;
          end else begin
            w_state_nxt = ST_CRD;
          end
        end
      end
      ST_JRD: begin
        w_state_nxt = ST_IDLE;
      end
      ST_CRD: begin
        w_cpu_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and grant history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_last_jtag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_j || w_grant_c) r_last_jtag <= w_grant_j;
    end
  end

  // JTAG address: an explicit load beats the post-op increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jaddr <= LP_RESET_ADDR;
    end else if (take_action_ocimem_a) begin
      r_jaddr <= jdo[17 +: ADDR_W];
    end else if (w_jop_done) begin
      r_jaddr <= r_jaddr + ADDR_W'(1);
    end
  end

  // 1-deep pending JTAG op; a write pulse wins if both arrive together, the read is flagged as lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend      <= 1'b0;
      r_pend_wr   <= 1'b0;
      r_pend_data <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_rw_pulse && !w_busy) begin
        r_pend    <= 1'b1;
        r_pend_wr <= take_action_ocimem_b;
        if (take_action_ocimem_b) r_pend_data <= jdo[34:3];
      end else if (w_jop_done) begin
        r_pend <= 1'b0;
      end
      if ((w_rw_pulse && w_busy) || (take_action_ocimem_b && take_no_action_ocimem_a)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // returned data registers for the JTAG and CPU sides
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mondreg   <= '0;
      r_cpu_rdata <= '0;
    end else begin
      if (w_jwr_done) begin
        r_mondreg <= r_pend_data;
      end else if (r_state == ST_JRD) begin
        r_mondreg <= ram_rdata;
      end
      if (r_state == ST_CRD) r_cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_hw_nios_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Purpose: self-checking bench for the OCI memory arbiter against a word-array reference model.
// Latency: drives inputs 1 time unit after the rising edge, samples combinational outputs on the falling edge.
// Backpressure: CPU requests are held until cpu_waitrequest drops, bounded by a cycle budget.
module tb_hw_nios_nios2_gen2_0_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_debugaccess;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        jtag_busy;
  logic        jtag_overrun;

  always #5 clk = ~clk;

  hw_nios_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(8), .RESET_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_debugaccess(cpu_debugaccess), .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest), .ram_addr(ram_addr), .ram_wren(ram_wren),
    .ram_byteen(ram_byteen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
  );

  // single-port debug RAM with byte enables and registered read
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  // reference model: memory image, JTAG address pointer, monitor register
  logic [31:0] exp_mem [256];
  logic [7:0]  exp_jaddr;
  logic [31:0] exp_mon;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulses();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  // kind: 0 address load, 1 write, 2 read; lat = cycles until jtag_busy drops
  task automatic jtag_op(input int kind, input logic [31:0] val, output int lat);
    jdo = '0;
    if (kind == 0) jdo[17 +: 8] = val[7:0];
    else           jdo[34:3]    = val;
    take_action_ocimem_a    = (kind == 0);
    take_action_ocimem_b    = (kind == 1);
    take_no_action_ocimem_a = (kind == 2);
    step();
    clr_pulses();
    lat = 0;
    while (jtag_busy && lat < 10) begin
      step();
      lat++;
    end
    check("jtag_busy_clear", {31'b0, jtag_busy}, 32'd0);
    case (kind)
      0: exp_jaddr = val[7:0];
      1: begin exp_mem[exp_jaddr] = val; exp_mon = val; exp_jaddr++; end
      default: begin exp_mon = exp_mem[exp_jaddr]; exp_jaddr++; end
    endcase
    check("mondreg", MonDReg, exp_mon);
  endtask

  // single CPU access with no JTAG activity; waited = stalled cycles before completion
  task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit dbg, output int waited);
    logic        ok;
    logic [31:0] got;
    cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_debugaccess = dbg;
    cpu_write = wr; cpu_read = !wr;
    ok = 1'b0; got = '0; waited = 0;
    while (!ok && waited < 10) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin
        ok  = 1'b1;
        got = cpu_readdata;
      end
      step();
      if (!ok) waited++;
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    check("cpu_complete", {31'b0, ok}, 32'd1);
    if (wr) begin
      if (dbg)
        for (int b = 0; b < 4; b++)
          if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      check("cpu_rdata", got, exp_mem[a]);
    end
  endtask

  // continuous CPU reads of 0x20 with JTAG pulses (kind 1 write, 2 read) injected at chosen cycles
  task automatic cpu_stream(input int ncyc, input int p1, input int k1, input int p2, input int k2,
                            input logic [31:0] wd, output int ncomp);
    int n;
    cpu_address = 8'h20; cpu_read = 1'b1; cpu_write = 1'b0;
    ncomp = 0;
    for (int i = 0; i < ncyc; i++) begin
      clr_pulses();
      jdo = '0;
      jdo[34:3] = wd;
      if ((i == p1 && k1 == 1) || (i == p2 && k2 == 1)) take_action_ocimem_b = 1'b1;
      if ((i == p1 && k1 == 2) || (i == p2 && k2 == 2)) take_no_action_ocimem_a = 1'b1;
      @(negedge clk);
      if (!cpu_waitrequest) begin
        ncomp++;
        check("stream_rdata", cpu_readdata, exp_mem[8'h20]);
      end
      step();
    end
    clr_pulses();
    cpu_read = 1'b0;
    n = 0;
    while (jtag_busy && n < 10) begin
      step();
      n++;
    end
    check("stream_jtag_drained", {31'b0, jtag_busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int w;
    int nc;
    logic [31:0] old;
    logic [31:0] rd;
    reset_n = 1'b0;
    jdo = '0;
    clr_pulses();
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_writedata = '0; cpu_byteenable = '0; cpu_debugaccess = 1'b0;
    exp_jaddr = 8'h00;
    exp_mon = '0;
    #2;
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_busy", {31'b0, jtag_busy}, 32'd0);
    check("rst_overrun", {31'b0, jtag_overrun}, 32'd0);
    check("rst_wren", {31'b0, ram_wren}, 32'd0);
    check("rst_cpu_rdata", cpu_readdata, 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // fill memory through the CPU port so model and RAM agree
    for (int a = 0; a < 256; a++) begin
      rd = $urandom;
      cpu_op(1'b1, 8'(a), rd, 4'hF, 1'b1, w);
    end

    // JTAG load then write
    jtag_op(0, 32'h10, lat);
    jtag_op(1, 32'hDEADBEEF, lat);
    check("jwr_latency", 32'(lat), 32'd1);
    check("jwr_ram", mem[8'h10], 32'hDEADBEEF);
    check("jwr_mondreg", MonDReg, 32'hDEADBEEF);

    // JTAG read of the auto-incremented address
    cpu_op(1'b1, 8'h11, 32'h12345678, 4'hF, 1'b1, w);
    jtag_op(2, 32'h0, lat);
    check("jrd_latency", 32'(lat), 32'd2);
    check("jrd_mondreg", MonDReg, 32'h12345678);
    jtag_op(1, 32'hCAFEF00D, lat);
    check("jaddr_0x12", mem[8'h12], 32'hCAFEF00D);

    // CPU write permissions and byte enables, CPU read latency
    old = exp_mem[8'h05];
    cpu_op(1'b1, 8'h05, 32'hA5A5A5A5, 4'hF, 1'b0, w);
    check("cwr_nodbg_wait", 32'(w), 32'd0);
    check("cwr_nodbg_ram", mem[8'h05], old);
    cpu_op(1'b1, 8'h05, 32'hA5A5A5A5, 4'b0011, 1'b1, w);
    check("cwr_be_ram", mem[8'h05], {old[31:16], 16'hA5A5});
    cpu_op(1'b0, 8'h05, 32'h0, 4'hF, 1'b0, w);
    check("crd_latency", 32'(w), 32'd1);

    // contention: JTAG write against a continuous CPU read stream
    jtag_op(0, 32'h40, lat);
    cpu_stream(16, 4, 1, -1, 0, 32'h0BADF00D, nc);
    exp_mem[exp_jaddr] = 32'h0BADF00D;
    exp_mon = 32'h0BADF00D;
    check("cont_jwr_ram", mem[8'h40], 32'h0BADF00D);
    check("cont_mondreg", MonDReg, exp_mon);
    exp_jaddr++;
    check("cont_cpu_served", {31'b0, (nc >= 5)}, 32'd1);
    check("cont_no_overrun", {31'b0, jtag_overrun}, 32'd0);

    // overrun: back-to-back read pulses, only the first is performed
    cpu_stream(12, 2, 2, 3, 2, 32'h0, nc);
    exp_mon = exp_mem[exp_jaddr];
    exp_jaddr++;
    check("ovr_flag", {31'b0, jtag_overrun}, 32'd1);
    check("ovr_mondreg", MonDReg, exp_mon);
    jtag_op(1, 32'h5EED0001, lat);
    check("ovr_single_inc", mem[8'h42], 32'h5EED0001);

    // address wrap
    jtag_op(0, 32'hFF, lat);
    jtag_op(1, 32'h11112222, lat);
    jtag_op(1, 32'h33334444, lat);
    check("wrap_ff", mem[8'hFF], 32'h11112222);
    check("wrap_00", mem[8'h00], 32'h33334444);

    // asynchronous reset while a JTAG read is in flight
    jtag_op(0, 32'h80, lat);
    take_no_action_ocimem_a = 1'b1;
    step();
    clr_pulses();
    step();
    check("mid_read_busy", {31'b0, jtag_busy}, 32'd1);
    reset_n = 1'b0;
    #2;
    check("rstmid_mondreg", MonDReg, 32'd0);
    check("rstmid_busy", {31'b0, jtag_busy}, 32'd0);
    check("rstmid_overrun", {31'b0, jtag_overrun}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    exp_jaddr = 8'h00;
    exp_mon = '0;
    jtag_op(1, 32'h0A0B0C0D, lat);
    check("rstmid_jaddr", mem[8'h00], 32'h0A0B0C0D);
    cpu_op(1'b0, 8'h80, 32'h0, 4'hF, 1'b0, w);

    // randomized mix of isolated JTAG and CPU operations
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: jtag_op(0, 32'($urandom_range(0, 255)), lat);
        1: jtag_op(1, $urandom, lat);
        2: jtag_op(2, 32'h0, lat);
        3: cpu_op(1'b1, 8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), w);
        default: cpu_op(1'b0, 8'($urandom_range(0, 255)), 32'h0, 4'hF, 1'b0, w);
      endcase
    end
    for (int a = 0; a < 256; a += 37) check("final_ram", mem[a], exp_mem[a]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
